counter_arbiter: RTL and testbench

COUNTER_ARBITER -- requirements
Module: counter_arbiter

---
 rtl/counter_arbiter.sv | 138 +++++++++++++
 tb/tb_counter_arbiter.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_arbiter.sv
// counter_arbiter: round-robin arbiter that lets NUM_REQ requesters share a
// single external counter. One command is in flight at a time; it walks
// IDLE -> ISSUE -> SAMPLE -> RESP, driving one counter strobe in ISSUE and
// returning the counter value seen after that strobe.
module counter_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int WIDTH   = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [2*NUM_REQ-1:0]       req_op,
    input  logic [WIDTH*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       ctr_ld,
    output logic                       ctr_inc,
    output logic [WIDTH-1:0]           ctr_data,
    input  logic [WIDTH-1:0]           ctr_count,
    output logic                       rsp_valid,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id,
    output logic [WIDTH-1:0]           rsp_count,
    input  logic                       rsp_ready
);

    localparam int ID_W = $clog2(NUM_REQ);
    // One spare bit so rr_ptr + offset never overflows before the modulo fold.
    localparam logic [ID_W:0]   NUM_REQ_X = (ID_W+1)'(NUM_REQ);
    localparam logic [ID_W-1:0] LAST_ID   = ID_W'(NUM_REQ - 1);

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_INC   = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        SAMPLE = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t            state;
    logic [ID_W-1:0]   rr_ptr;

    logic              grant_vld;
    logic [ID_W-1:0]   grant_id;
    logic [ID_W:0]     cand;
    logic [1:0]        grant_op;
    logic [WIDTH-1:0]  grant_data;

    // Round-robin search: first valid requester at or after rr_ptr, wrapping.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        cand      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, rr_ptr} + (ID_W+1)'(i);
            if (cand >= NUM_REQ_X) begin
                cand = cand - NUM_REQ_X;
            end
            if (!grant_vld && req_valid[cand[ID_W-1:0]]) begin
                grant_vld = 1'b1;
                grant_id  = cand[ID_W-1:0];
            end
        end
    end

    // Select the winning requester's opcode and load value.
    always_comb begin
        grant_op   = OP_READ;
        grant_data = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (grant_id == ID_W'(j)) begin
                grant_op   = req_op[2*j +: 2];
                grant_data = req_data[WIDTH*j +: WIDTH];
            end
        end
    end

    // Accept is combinational so the winner sees it in the grant cycle itself;
    // it is gated with rst_n so reset silences it without waiting for an edge.
    always_comb begin
        req_ready = '0;
        if (rst_n && (state == IDLE) && grant_vld) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    // Command sequencer: strobes are registered at the grant edge so they are
    // live for exactly the ISSUE cycle, and the response is captured in SAMPLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            ctr_ld    <= 1'b0;
            ctr_inc   <= 1'b0;
            ctr_data  <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        rsp_id   <= grant_id;
                        rr_ptr   <= (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
                        ctr_ld   <= (grant_op == OP_LOAD) || (grant_op == OP_CLEAR);
                        ctr_inc  <= (grant_op == OP_INC);
                        ctr_data <= (grant_op == OP_LOAD) ? grant_data : '0;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    ctr_ld   <= 1'b0;
                    ctr_inc  <= 1'b0;
                    ctr_data <= '0;
                    state    <= SAMPLE;
                end
                SAMPLE: begin
                    // The counter is registered, so the ISSUE strobe shows up now.
                    rsp_count <= ctr_count;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_counter_arbiter.sv
// Testbench for counter_arbiter: directed scenarios plus a randomized run,
// with a command-level reference model checking every cycle.
module tb_counter_arbiter;

    localparam int NR  = 3;
    localparam int W   = 16;
    localparam int IDW = $clog2(NR);

    typedef logic [NR-1:0]   vld_t;
    typedef logic [2*NR-1:0] opv_t;
    typedef logic [W*NR-1:0] datv_t;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_INC   = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    vld_t           req_valid = '0;
    opv_t           req_op = '0;
    datv_t          req_data = '0;
    vld_t           req_ready;
    logic           ctr_ld;
    logic           ctr_inc;
    logic [W-1:0]   ctr_data;
    logic [W-1:0]   ctr_count = '0;
    logic           rsp_valid;
    logic [IDW-1:0] rsp_id;
    logic [W-1:0]   rsp_count;
    logic           rsp_ready = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state (command level)
    bit           m_busy = 1'b0;
    int           m_ptr = 0;
    int           m_age = 0;
    int           m_id = 0;
    logic [1:0]   m_op = 2'b00;
    logic [W-1:0] m_data = '0;
    logic [W-1:0] m_ref = '0;
    int           m_grants = 0;

    always #5 clk = ~clk;

    counter_arbiter #(.NUM_REQ(NR), .WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_op    (req_op),
        .req_data  (req_data),
        .req_ready (req_ready),
        .ctr_ld    (ctr_ld),
        .ctr_inc   (ctr_inc),
        .ctr_data  (ctr_data),
        .ctr_count (ctr_count),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_count (rsp_count),
        .rsp_ready (rsp_ready)
    );

    // External registered counter driven by the strobes
    always @(posedge clk) begin
        if (ctr_ld) ctr_count <= ctr_data;
        else if (ctr_inc) ctr_count <= ctr_count + 1'b1;
    end

    function automatic bit vbit(vld_t v, int i);
        return 1'(v >> i);
    endfunction

    task automatic set_req(int i, logic [1:0] op, logic [W-1:0] d);
        req_valid = req_valid | (vld_t'(1) << i);
        req_op    = (req_op & ~(opv_t'(3) << (2*i))) | (opv_t'(op) << (2*i));
        req_data  = (req_data & ~(datv_t'({W{1'b1}}) << (W*i))) | (datv_t'(d) << (W*i));
    endtask

    task automatic drop_req(int i);
        req_valid = req_valid & ~(vld_t'(1) << i);
    endtask

    // Runs cycles until one response handshake; granted requesters drop valid.
    task automatic serve(output int id, output logic [W-1:0] cnt, output bit ok);
        int gi;
        ok = 1'b0; id = -1; cnt = '0; gi = -1;
        for (int c = 0; c < 40 && !ok; c++) begin
            @(negedge clk);
            for (int k = 0; k < NR; k++) if (vbit(req_ready, k)) gi = k;
            if (rsp_valid && rsp_ready) begin
                id = int'(rsp_id); cnt = rsp_count; ok = 1'b1;
            end
            @(posedge clk); #1;
            if (gi >= 0) begin drop_req(gi); gi = -1; end
        end
    endtask

    // Per-cycle reference model and invariant checks
    initial begin
        int g, na;
        vld_t exp_rdy;
        logic e_ld, e_inc;
        logic [W-1:0] e_data;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                vectors++;
                if ({req_ready, ctr_ld, ctr_inc, ctr_data, rsp_valid, rsp_id, rsp_count} !== '0) begin
                    miscompares++;
                    $display("FAIL reset_outputs: got ready=%b ld=%b inc=%b data=%h rv=%b id=%0d cnt=%h, required all zero",
                             req_ready, ctr_ld, ctr_inc, ctr_data, rsp_valid, rsp_id, rsp_count);
                end
                m_busy = 1'b0; m_ptr = 0; m_age = 0;
            end else begin
                vectors++;
                if ((ctr_ld && ctr_inc) || (!ctr_ld && ctr_data !== '0) || !$onehot0(req_ready)) begin
                    miscompares++;
                    $display("FAIL invariant: got ld=%b inc=%b data=%h ready=%b, required exclusive strobes, zero data without ld, one-hot ready",
                             ctr_ld, ctr_inc, ctr_data, req_ready);
                end
                if (!m_busy) begin
                    g = -1;
                    for (int k = 0; k < NR; k++) begin
                        if (g < 0 && vbit(req_valid, (m_ptr + k) % NR)) g = (m_ptr + k) % NR;
                    end
                    exp_rdy = (g >= 0) ? (vld_t'(1) << g) : '0;
                    vectors++;
                    if ({req_ready, ctr_ld, ctr_inc, rsp_valid} !== {exp_rdy, 3'b000}) begin
                        miscompares++;
                        $display("FAIL idle_grant: got ready=%b ld=%b inc=%b rv=%b, required ready=%b and no strobe/response",
                                 req_ready, ctr_ld, ctr_inc, rsp_valid, exp_rdy);
                    end
                    if (g >= 0) begin
                        m_busy = 1'b1; m_age = 0; m_id = g;
                        m_op   = 2'(req_op >> (2*g));
                        m_data = W'(req_data >> (W*g));
                        m_ptr  = (g + 1) % NR;
                        m_grants++;
                    end
                end else begin
                    na = m_age + 1;
                    m_age = na;
                    e_ld   = (na == 1) && (m_op == OP_LOAD || m_op == OP_CLEAR);
                    e_inc  = (na == 1) && (m_op == OP_INC);
                    e_data = (na == 1 && m_op == OP_LOAD) ? m_data : '0;
                    if (na == 1) begin
                        case (m_op)
                            OP_LOAD:  m_ref = m_data;
                            OP_CLEAR: m_ref = '0;
                            OP_INC:   m_ref = m_ref + 1'b1;
                            default:  m_ref = m_ref;
                        endcase
                    end
                    vectors++;
                    if ({req_ready, ctr_ld, ctr_inc, ctr_data, rsp_valid} !== {vld_t'(0), e_ld, e_inc, e_data, (na >= 3)}) begin
                        miscompares++;
                        $display("FAIL busy_outputs: age=%0d got ready=%b ld=%b inc=%b data=%h rv=%b, required ready=0 ld=%b inc=%b data=%h rv=%b",
                                 na, req_ready, ctr_ld, ctr_inc, ctr_data, rsp_valid, e_ld, e_inc, e_data, (na >= 3));
                    end
                    if (na >= 3) begin
                        vectors++;
                        if (rsp_id !== IDW'(m_id) || rsp_count !== m_ref) begin
                            miscompares++;
                            $display("FAIL response: got id=%0d cnt=%h, required id=%0d cnt=%h",
                                     rsp_id, rsp_count, m_id, m_ref);
                        end
                        if (rsp_ready) m_busy = 1'b0;
                    end
                end
            end
        end
    end

    task automatic test_reset();
        for (int i = 0; i < NR; i++) set_req(i, OP_LOAD, 16'h5A5A);
        rsp_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            vectors++;
            if ({req_ready, ctr_ld, ctr_inc, ctr_data, rsp_valid, rsp_id, rsp_count} !== '0) begin
                miscompares++;
                $display("FAIL test_reset: got ready=%b ld=%b rv=%b cnt=%h, required all zero",
                         req_ready, ctr_ld, rsp_valid, rsp_count);
            end
        end
        req_valid = '0;
        @(posedge clk); #2;
        rst_n = 1'b1;
    endtask

    task automatic test_single_load();
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        set_req(0, OP_LOAD, 16'h1234);
        @(negedge clk);
        vectors++;
        if (req_ready !== 3'b001) begin
            miscompares++; $display("FAIL single_grant: got ready=%b, required 001", req_ready);
        end
        @(posedge clk); #1;
        drop_req(0);
        @(negedge clk);
        vectors++;
        if ({ctr_ld, ctr_inc, ctr_data} !== {1'b1, 1'b0, 16'h1234}) begin
            miscompares++; $display("FAIL single_strobe: got ld=%b inc=%b data=%h, required 1 0 1234", ctr_ld, ctr_inc, ctr_data);
        end
        @(negedge clk);
        vectors++;
        if ({ctr_ld, ctr_inc, rsp_valid} !== 3'b000) begin
            miscompares++; $display("FAIL single_sample: got ld=%b inc=%b rv=%b, required 000", ctr_ld, ctr_inc, rsp_valid);
        end
        @(negedge clk);
        vectors++;
        if ({rsp_valid, rsp_id, rsp_count} !== {1'b1, IDW'(0), 16'h1234}) begin
            miscompares++; $display("FAIL single_resp: got rv=%b id=%0d cnt=%h, required 1 0 1234", rsp_valid, rsp_id, rsp_count);
        end
        @(negedge clk);
        vectors++;
        if (rsp_valid !== 1'b0) begin
            miscompares++; $display("FAIL single_done: got rv=%b, required 0", rsp_valid);
        end
    endtask

    task automatic test_round_robin();
        int id; logic [W-1:0] cnt; bit ok;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        set_req(2, OP_LOAD, 16'd5);
        serve(id, cnt, ok);
        vectors++;
        if (!ok || id !== 2 || cnt !== 16'd5) begin
            miscompares++; $display("FAIL rr_preload: got ok=%b id=%0d cnt=%h, required 1 2 0005", ok, id, cnt);
        end
        for (int i = 0; i < NR; i++) set_req(i, OP_INC, 16'hDEAD);
        for (int i = 0; i < NR; i++) begin
            serve(id, cnt, ok);
            vectors++;
            if (!ok || id !== i || cnt !== W'(6 + i)) begin
                miscompares++; $display("FAIL rr_order: got ok=%b id=%0d cnt=%h, required 1 %0d %h", ok, id, cnt, i, W'(6 + i));
            end
        end
    endtask

    task automatic test_backpressure();
        bit got, granted;
        got = 1'b0; granted = 1'b0;
        rsp_ready = 1'b0;
        @(posedge clk); #1;
        set_req(1, OP_READ, 16'hBEEF);
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (rsp_valid) got = 1'b1;
            else begin
                if (vbit(req_ready, 1)) granted = 1'b1;
                @(posedge clk); #1;
                if (granted) begin
                    drop_req(1); set_req(0, OP_INC, '0); set_req(2, OP_INC, '0); granted = 1'b0;
                end
            end
        end
        vectors++;
        if (!got) begin
            miscompares++; $display("FAIL bp_timeout: got no rsp_valid within 20 cycles, required response");
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            vectors++;
            if ({rsp_valid, rsp_id, rsp_count, req_ready, ctr_ld, ctr_inc} !== {1'b1, IDW'(1), 16'd8, vld_t'(0), 2'b00}) begin
                miscompares++;
                $display("FAIL bp_hold: got rv=%b id=%0d cnt=%h ready=%b ld=%b inc=%b, required 1 1 0008 000 0 0",
                         rsp_valid, rsp_id, rsp_count, req_ready, ctr_ld, ctr_inc);
            end
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1; drop_req(0); drop_req(2);
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if ({rsp_valid, req_ready} !== '0) begin
            miscompares++; $display("FAIL bp_release: got rv=%b ready=%b, required 0 000", rsp_valid, req_ready);
        end
    endtask

    task automatic test_wrap();
        int r[6] = '{0, 1, 2, 0, 1, 2};
        logic [1:0] o[6] = '{OP_LOAD, OP_INC, OP_LOAD, OP_CLEAR, OP_LOAD, OP_READ};
        logic [W-1:0] d[6] = '{16'hFFFF, 16'h0000, 16'h0042, 16'h0000, 16'h0077, 16'h1111};
        logic [W-1:0] e[6] = '{16'hFFFF, 16'h0000, 16'h0042, 16'h0000, 16'h0077, 16'h0077};
        int id; logic [W-1:0] cnt; bit ok;
        rsp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            set_req(r[i], o[i], d[i]);
            serve(id, cnt, ok);
            vectors++;
            if (!ok || id !== r[i] || cnt !== e[i]) begin
                miscompares++; $display("FAIL wrap_step%0d: got ok=%b id=%0d cnt=%h, required 1 %0d %h", i, ok, id, cnt, r[i], e[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit granted;
        int id; logic [W-1:0] cnt; bit ok;
        granted = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        set_req(1, OP_LOAD, 16'h00AA);
        for (int c = 0; c < 5 && !granted; c++) begin
            @(negedge clk);
            if (vbit(req_ready, 1)) granted = 1'b1;
        end
        @(posedge clk); #1;
        drop_req(1);
        vectors++;
        if (!granted || {ctr_ld, ctr_data} !== {1'b1, 16'h00AA}) begin
            miscompares++; $display("FAIL mid_issue: got granted=%b ld=%b data=%h, required 1 1 00aa", granted, ctr_ld, ctr_data);
        end
        #1;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({req_ready, ctr_ld, ctr_inc, ctr_data, rsp_valid, rsp_id, rsp_count} !== '0) begin
            miscompares++; $display("FAIL mid_async: got ld=%b data=%h rv=%b cnt=%h, required all zero", ctr_ld, ctr_data, rsp_valid, rsp_count);
        end
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            vectors++;
            if ({rsp_valid, ctr_ld, ctr_inc} !== 3'b000) begin
                miscompares++; $display("FAIL mid_abandon: got rv=%b ld=%b inc=%b, required 000", rsp_valid, ctr_ld, ctr_inc);
            end
        end
        @(posedge clk); #1;
        for (int i = 0; i < NR; i++) set_req(i, OP_READ, '0);
        @(negedge clk);
        vectors++;
        if (req_ready !== 3'b001) begin
            miscompares++; $display("FAIL mid_first_grant: got ready=%b, required 001", req_ready);
        end
        @(posedge clk); #1;
        drop_req(0);
        for (int i = 0; i < NR; i++) begin
            serve(id, cnt, ok);
            vectors++;
            if (!ok || id !== i || cnt !== 16'h0077) begin
                miscompares++; $display("FAIL mid_drain: got ok=%b id=%0d cnt=%h, required 1 %0d 0077", ok, id, cnt, i);
            end
        end
    endtask

    task automatic test_random();
        int hs, g0;
        vld_t gmask;
        hs = 0; g0 = m_grants; gmask = '0;
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            for (int k = 0; k < NR; k++) begin
                if (vbit(gmask, k) || (vbit(req_valid, k) && $urandom_range(0, 3) == 0)) begin
                    drop_req(k);
                end
                if (!vbit(req_valid, k) && $urandom_range(0, 2) == 0) begin
                    set_req(k, 2'($urandom_range(0, 3)), W'($urandom));
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            gmask = req_ready;
            if (rsp_valid && rsp_ready) hs++;
        end
        @(posedge clk); #1;
        req_valid = '0; rsp_ready = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (rsp_valid && rsp_ready) hs++;
        end
        vectors++;
        if (hs !== m_grants - g0) begin
            miscompares++; $display("FAIL random_count: got %0d responses, required %0d", hs, m_grants - g0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation time limit, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single_load();
        test_round_robin();
        test_backpressure();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
